tdt_dtm_tap_ctrl: RTL and testbench
===================================

Name: tdt_dtm_tap_ctrl

Overview:
- IEEE 1149.1 TAP state machine plus 2-wire (jtag2) phase sequencer for the debug transport module.
- Drives the pad IO block's TDO/TMS output enables and supplies capture/shift/update strobes to the DR/IR scan chain.
- Sits between the pad IO block and the scan-chain block, in the TCLK domain.

Parameters:
- STATE_W, 4, TAP state encoding width (16 states).
- JTAG2_TRN, 1, turnaround cycles between host data phase and device TDO phase in 2-wire mode; legal range 0..3.

Ports:
- pad_dtm_tclk  in  1  JTAG test clock; the only clock.
- pad_dtm_trst_b  in  1  asynchronous active-low reset.
- io_ctrl_tap_en  in  1  TAP enable from pad IO; low forces and holds Test-Logic-Reset.
- pad_dtm_jtag2_sel  in  1  1 = 2-wire mode, 0 = 4-wire mode.
- pad_dtm_tms_i  in  1  TMS input (control bit; also data bit in 2-wire mode).
- ctrl_io_tdo_en  out  1  TDO pad output enable (4-wire).
- ctrl_io_tms_oe  out  1  TMS pad output enable (2-wire TDO phase).
- ctrl_chain_tlr  out  1  FSM is in Test-Logic-Reset.
- ctrl_chain_capture_dr / ctrl_chain_capture_ir  out  1 each  one-cycle capture strobes.
- ctrl_chain_shift_dr / ctrl_chain_shift_ir  out  1 each  FSM in Shift-DR / Shift-IR.
- ctrl_chain_shift_en  out  1  chain shifts one bit this cycle.
- ctrl_chain_update_dr / ctrl_chain_update_ir  out  1 each  one-cycle update strobes.
- ctrl_chain_state  out  STATE_W  current TAP state, for debug visibility.

Behaviour:
- Clocking: single clock, pad_dtm_tclk; all flops on its rising edge. Reset is asynchronous and active-low on pad_dtm_trst_b.
- Reset: state = Test-Logic-Reset (TLR), phase = CTRL, mode = 4-wire. ctrl_chain_tlr = 1; every other output = 0.
- io_ctrl_tap_en = 0: state held in TLR and phase held in CTRL at the next edge, from any state.
- Mode latch: pad_dtm_jtag2_sel is captured into the mode flop only on edges where state is TLR. Changes in any other state are ignored.
- TAP FSM: standard 16-state 1149.1 transition table on the control bit.
  - Five consecutive control bits of 1 reach TLR from any state.
- 4-wire mode:
  - Control bit = pad_dtm_tms_i; one FSM advance per clock.
  - ctrl_chain_shift_en = shift_dr | shift_ir.
  - ctrl_io_tdo_en = 1 while state is Shift-DR or Shift-IR.
  - ctrl_io_tms_oe = 0.
- 2-wire mode, outside Shift-DR/IR: one FSM advance per clock on pad_dtm_tms_i.
- 2-wire mode, inside Shift-DR/IR: each bit is a frame of 2+JTAG2_TRN+1 clocks.
  - CTRL phase: sample pad_dtm_tms_i as the control bit; hold it, do not advance the FSM.
  - DATA phase: ctrl_chain_shift_en = 1; the chain samples TDI, which the pad IO block supplies from TMS.
  - TRN phases: JTAG2_TRN clocks with no drive.
  - TDO phase: ctrl_io_tms_oe = 1; FSM advances on the held control bit; phase returns to CTRL.
  - ctrl_io_tdo_en = 0 throughout 2-wire mode.
  - With JTAG2_TRN = 0, DATA is followed directly by TDO.
- Strobes:
  - capture_* = 1 during the single cycle in Capture-DR/IR.
  - update_* = 1 during the single cycle in Update-DR/IR.
  - All strobes and enables are decoded from registered state and phase, so they are glitch-free.
- Reset mid-frame: trst_b low returns state and phase to reset values asynchronously. ctrl_io_tms_oe and ctrl_io_tdo_en drop immediately.
- tap_en low mid-frame: the frame is abandoned and outputs are cleared at the next edge.
- Phase counter width is 2 bits; it wraps only through the TDO→CTRL transition and never overflows for legal JTAG2_TRN.

Decomposition:
- Shared package tdt_dtm_pkg holds:
  - the 16 TAP state encodings (localparams, STATE_W wide);
  - the 2-wire phase encodings CTRL/DATA/TRN/TDO.
- One sub-module is natural: tdt_dtm_tap_fsm, the pure 1149.1 next-state logic and state register with an advance-enable input.
- The top level adds the mode latch, phase sequencer and output decode.

Test Plan:
- Reset then tap_en = 1, TMS = 0,1,0,0 in 4-wire mode -> states RTI, Select-DR, Capture-DR (capture_dr = 1 one cycle), Shift-DR; shift_en = tdo_en = 1 from the Shift-DR cycle.
- From Shift-IR, drive TMS = 1 for 5 clocks -> Exit1-IR, Update-IR (update_ir = 1), Select-DR, Select-IR, TLR; ctrl_chain_tlr = 1.
- 2-wire mode, JTAG2_TRN = 1, in Shift-DR, frames with control bits 0,0,1 -> 4-clock frames; shift_en on clock 2 of each frame; tms_oe on clock 4; state reaches Exit1-DR after the third frame's TDO phase.
- Toggle pad_dtm_jtag2_sel while in Shift-DR -> mode unchanged until the next TLR; tdo_en behaviour unchanged.
- Assert trst_b low during a 2-wire TRN phase -> all outputs 0 asynchronously, ctrl_chain_tlr = 1; after release, state = TLR, phase = CTRL.
- Deassert io_ctrl_tap_en while in Pause-DR -> TLR at the next edge; FSM ignores TMS until tap_en returns to 1.

Source files
------------

// File: rtl/tdt_dtm_pkg.sv
// tdt_dtm_pkg: TAP state encodings and 2-wire phase encodings shared by the DTM TAP controller.
package tdt_dtm_pkg;
  localparam int TAP_W = 4;
  localparam logic [TAP_W-1:0] ST_TLR      = 4'hF;
  localparam logic [TAP_W-1:0] ST_RTI      = 4'hC;
  localparam logic [TAP_W-1:0] ST_SEL_DR   = 4'h7;
  localparam logic [TAP_W-1:0] ST_CAP_DR   = 4'h6;
  localparam logic [TAP_W-1:0] ST_SHIFT_DR = 4'h2;
  localparam logic [TAP_W-1:0] ST_EX1_DR   = 4'h1;
  localparam logic [TAP_W-1:0] ST_PAUSE_DR = 4'h3;
  localparam logic [TAP_W-1:0] ST_EX2_DR   = 4'h0;
  localparam logic [TAP_W-1:0] ST_UPD_DR   = 4'h5;
  localparam logic [TAP_W-1:0] ST_SEL_IR   = 4'h4;
  localparam logic [TAP_W-1:0] ST_CAP_IR   = 4'hE;
  localparam logic [TAP_W-1:0] ST_SHIFT_IR = 4'hA;
  localparam logic [TAP_W-1:0] ST_EX1_IR   = 4'h9;
  localparam logic [TAP_W-1:0] ST_PAUSE_IR = 4'hB;
  localparam logic [TAP_W-1:0] ST_EX2_IR   = 4'h8;
  localparam logic [TAP_W-1:0] ST_UPD_IR   = 4'hD;
  typedef enum logic [1:0] {PH_CTRL, PH_DATA, PH_TRN, PH_TDO} phase_e;
endpackage

// File: rtl/tdt_dtm_tap_fsm.sv
// tdt_dtm_tap_fsm: IEEE 1149.1 TAP next-state logic and state register with advance enable.
module tdt_dtm_tap_fsm
  import tdt_dtm_pkg::*;
#(
  parameter int STATE_W = TAP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_force_tlr,
  input  logic               i_adv,
  input  logic               i_tms,
  output logic [STATE_W-1:0] o_state
);
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  always_comb begin
    w_next = ST_TLR;
    case (r_state)
      ST_TLR:      w_next = i_tms ? ST_TLR    : ST_RTI;
      ST_RTI:      w_next = i_tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR:   w_next = i_tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR:   w_next = i_tms ? ST_EX1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: w_next = i_tms ? ST_EX1_DR : ST_SHIFT_DR;
      ST_EX1_DR:   w_next = i_tms ? ST_UPD_DR : ST_PAUSE_DR;
      ST_PAUSE_DR: w_next = i_tms ? ST_EX2_DR : ST_PAUSE_DR;
      ST_EX2_DR:   w_next = i_tms ? ST_UPD_DR : ST_SHIFT_DR;
      ST_UPD_DR:   w_next = i_tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR:   w_next = i_tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR:   w_next = i_tms ? ST_EX1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: w_next = i_tms ? ST_EX1_IR : ST_SHIFT_IR;
      ST_EX1_IR:   w_next = i_tms ? ST_UPD_IR : ST_PAUSE_IR;
      ST_PAUSE_IR: w_next = i_tms ? ST_EX2_IR : ST_PAUSE_IR;
      ST_EX2_IR:   w_next = i_tms ? ST_UPD_IR : ST_SHIFT_IR;
      ST_UPD_IR:   w_next = i_tms ? ST_SEL_DR : ST_RTI;
      default:     w_next = ST_TLR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_TLR;
    else if (i_force_tlr) r_state <= ST_TLR;
    else if (i_adv) r_state <= w_next;
  assign o_state = r_state;
endmodule

// File: rtl/tdt_dtm_tap_ctrl.sv
// tdt_dtm_tap_ctrl: TAP controller with 4-wire/2-wire mode latch, 2-wire phase sequencer and
// glitch-free chain strobes decoded from registered state and phase.
module tdt_dtm_tap_ctrl
  import tdt_dtm_pkg::*;
#(
  parameter int STATE_W   = 4,
  parameter int JTAG2_TRN = 1
) (
  input  logic               pad_dtm_tclk,
  input  logic               pad_dtm_trst_b,
  input  logic               io_ctrl_tap_en,
  input  logic               pad_dtm_jtag2_sel,
  input  logic               pad_dtm_tms_i,
  output logic               ctrl_io_tdo_en,
  output logic               ctrl_io_tms_oe,
  output logic               ctrl_chain_tlr,
  output logic               ctrl_chain_capture_dr,
  output logic               ctrl_chain_capture_ir,
  output logic               ctrl_chain_shift_dr,
  output logic               ctrl_chain_shift_ir,
  output logic               ctrl_chain_shift_en,
  output logic               ctrl_chain_update_dr,
  output logic               ctrl_chain_update_ir,
  output logic [STATE_W-1:0] ctrl_chain_state
);
  localparam logic [1:0] TRN_LAST = 2'(JTAG2_TRN - 1);
  logic [STATE_W-1:0] w_state;
  logic               r_mode;
  logic               r_ctl;
  phase_e             r_phase;
  logic [1:0]         r_trn;
  logic               w_in_shift;
  logic               w_frame;
  logic               w_adv;
  logic               w_tms;
  assign w_in_shift = (w_state == ST_SHIFT_DR) || (w_state == ST_SHIFT_IR);
  assign w_frame    = r_mode && w_in_shift;
  // In a 2-wire shift frame the FSM only moves in the TDO phase, on the bit held from CTRL.
  assign w_adv      = !w_frame || (r_phase == PH_TDO);
  assign w_tms      = w_frame ? r_ctl : pad_dtm_tms_i;
  tdt_dtm_tap_fsm #(.STATE_W(STATE_W)) u_fsm (
    .clk         (pad_dtm_tclk),
    .rst_n       (pad_dtm_trst_b),
    .i_force_tlr (!io_ctrl_tap_en),
    .i_adv       (w_adv),
    .i_tms       (w_tms),
    .o_state     (w_state)
  );
  always_ff @(posedge pad_dtm_tclk or negedge pad_dtm_trst_b)
    if (!pad_dtm_trst_b) begin
      r_mode  <= 1'b0;
      r_ctl   <= 1'b0;
      r_phase <= PH_CTRL;
      r_trn   <= 2'd0;
    end else begin
      if (w_state == ST_TLR) r_mode <= pad_dtm_jtag2_sel;
      if (!io_ctrl_tap_en || !w_frame) begin
        r_phase <= PH_CTRL;
        r_trn   <= 2'd0;
      end else begin
        case (r_phase)
          PH_CTRL: begin
            r_ctl   <= pad_dtm_tms_i;
            r_phase <= PH_DATA;
          end
          PH_DATA: r_phase <= (JTAG2_TRN == 0) ? PH_TDO : PH_TRN;
          PH_TRN: begin
            r_phase <= (r_trn == TRN_LAST) ? PH_TDO : PH_TRN;
            r_trn   <= (r_trn == TRN_LAST) ? 2'd0 : r_trn + 2'd1;
          end
          default: r_phase <= PH_CTRL;
        endcase
      end
    end
  assign ctrl_io_tdo_en        = !r_mode && w_in_shift;
  assign ctrl_io_tms_oe        = w_frame && (r_phase == PH_TDO);
  assign ctrl_chain_tlr        = w_state == ST_TLR;
  assign ctrl_chain_capture_dr = w_state == ST_CAP_DR;
  assign ctrl_chain_capture_ir = w_state == ST_CAP_IR;
  assign ctrl_chain_shift_dr   = w_state == ST_SHIFT_DR;
  assign ctrl_chain_shift_ir   = w_state == ST_SHIFT_IR;
  assign ctrl_chain_shift_en   = w_in_shift && (!r_mode || (r_phase == PH_DATA));
  assign ctrl_chain_update_dr  = w_state == ST_UPD_DR;
  assign ctrl_chain_update_ir  = w_state == ST_UPD_IR;
  assign ctrl_chain_state      = w_state;
endmodule

// File: tb/tb_tdt_dtm_tap_ctrl.sv
// tb_tdt_dtm_tap_ctrl: randomized bench for the DTM TAP controller against a graph-level TAP
// and frame-counting reference model.
module tb_tdt_dtm_tap_ctrl;
  import tdt_dtm_pkg::*;
  localparam int TRN = 1;
  localparam int FR  = 3 + TRN;
  localparam int S_TLR = 0, S_RTI = 1, S_SELDR = 2, S_CAPDR = 3, S_SHDR = 4, S_EX1DR = 5,
                 S_PDR = 6, S_EX2DR = 7, S_UPDDR = 8, S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11,
                 S_EX1IR = 12, S_PIR = 13, S_EX2IR = 14, S_UPDIR = 15;
  logic clk = 1'b0;
  logic trst_b, tap_en, sel, tms;
  logic tdo_en, tms_oe, tlr, cap_dr, cap_ir, sh_dr, sh_ir, sh_en, upd_dr, upd_ir;
  logic [3:0] state;
  logic [13:0] dut_v;
  int n_chk = 0, n_fail = 0;
  int m_st, m_k, m_mode;
  logic m_ctl;
  logic [3:0] enc [16] = '{ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EX1_DR,
                           ST_PAUSE_DR, ST_EX2_DR, ST_UPD_DR, ST_SEL_IR, ST_CAP_IR,
                           ST_SHIFT_IR, ST_EX1_IR, ST_PAUSE_IR, ST_EX2_IR, ST_UPD_IR};
  // Column positions: SEL, CAPTURE, SHIFT, EXIT1, PAUSE, EXIT2, UPDATE.
  int go0 [7] = '{1, 2, 2, 4, 4, 2, 0};
  int go1 [7] = '{0, 3, 3, 6, 5, 6, 0};

  always #5 clk = ~clk;

  tdt_dtm_tap_ctrl #(.STATE_W(4), .JTAG2_TRN(TRN)) dut (
    .pad_dtm_tclk          (clk),
    .pad_dtm_trst_b        (trst_b),
    .io_ctrl_tap_en        (tap_en),
    .pad_dtm_jtag2_sel     (sel),
    .pad_dtm_tms_i         (tms),
    .ctrl_io_tdo_en        (tdo_en),
    .ctrl_io_tms_oe        (tms_oe),
    .ctrl_chain_tlr        (tlr),
    .ctrl_chain_capture_dr (cap_dr),
    .ctrl_chain_capture_ir (cap_ir),
    .ctrl_chain_shift_dr   (sh_dr),
    .ctrl_chain_shift_ir   (sh_ir),
    .ctrl_chain_shift_en   (sh_en),
    .ctrl_chain_update_dr  (upd_dr),
    .ctrl_chain_update_ir  (upd_ir),
    .ctrl_chain_state      (state)
  );
  assign dut_v = {tdo_en, tms_oe, tlr, cap_dr, cap_ir, sh_dr, sh_ir, sh_en, upd_dr, upd_ir, state};

  function automatic int nxt(input int s, input logic t);
    int base, r;
    if (s == S_TLR) return t ? S_TLR : S_RTI;
    if (s == S_RTI) return t ? S_SELDR : S_RTI;
    base = (s >= S_SELIR) ? S_SELIR : S_SELDR;
    r = s - base;
    if (r == 0 && t) return (base == S_SELDR) ? S_SELIR : S_TLR;
    if (r == 6) return t ? S_SELDR : S_RTI;
    return base + (t ? go1[r] : go0[r]);
  endfunction

  function automatic logic in_sh(input int s);
    return (s == S_SHDR) || (s == S_SHIR);
  endfunction

  function automatic logic [13:0] exp_v();
    logic sh, en, oe;
    sh = in_sh(m_st);
    en = sh && ((m_mode == 0) || (m_k == 1));
    oe = sh && (m_mode == 1) && (m_k == FR - 1);
    return {sh && (m_mode == 0), oe, m_st == S_TLR, m_st == S_CAPDR, m_st == S_CAPIR,
            m_st == S_SHDR, m_st == S_SHIR, en, m_st == S_UPDDR, m_st == S_UPDIR, enc[m_st]};
  endfunction

  task automatic tick(input logic t);
    int old;
    tms = t;
    @(posedge clk);
    old = m_st;
    if (!tap_en) begin
      m_st = S_TLR;
      m_k  = 0;
    end else if (m_mode == 1 && in_sh(old)) begin
      if (m_k == 0) m_ctl = t;
      if (m_k == FR - 1) begin
        m_st = nxt(old, m_ctl);
        m_k  = 0;
      end else m_k++;
    end else m_st = nxt(old, t);
    if (old == S_TLR) m_mode = sel ? 1 : 0;
    #1;
  endtask

  task automatic do_reset();
    trst_b = 1'b0;
    #3;
    m_st = S_TLR; m_k = 0; m_mode = 0; m_ctl = 1'b0;
    trst_b = 1'b1;
  endtask

  task automatic goto_shdr();
    tick(0); tick(1); tick(0); tick(0);
  endtask

  task automatic test_reset();
    trst_b = 1'b0; tap_en = 1'b0; sel = 1'b0; tms = 1'b1;
    m_st = S_TLR; m_k = 0; m_mode = 0; m_ctl = 1'b0;
    #12;
    n_chk++;
    if (dut_v !== {2'b00, 1'b1, 7'b0, ST_TLR}) begin
      n_fail++; $display("FAIL reset: got %h exp %h", dut_v, {2'b00, 1'b1, 7'b0, ST_TLR});
    end
    trst_b = 1'b1; tap_en = 1'b1;
    tick(1);
    n_chk++;
    if (dut_v !== exp_v()) begin n_fail++; $display("FAIL reset_hold: got %h exp %h", dut_v, exp_v()); end
  endtask

  task automatic test_4wire_path();
    logic [3:0] want [4] = '{ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR};
    logic [3:0] seq = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick(seq[i]);
      n_chk++;
      if (state !== want[i]) begin n_fail++; $display("FAIL 4w_state%0d: got %h exp %h", i, state, want[i]); end
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL 4w_outs%0d: got %h exp %h", i, dut_v, exp_v()); end
    end
    n_chk++;
    if ({sh_en, tdo_en, tms_oe} !== 3'b110) begin
      n_fail++; $display("FAIL 4w_shift_en: got %b exp 110", {sh_en, tdo_en, tms_oe});
    end
  endtask

  task automatic test_tlr_by_five();
    logic [3:0] want [5] = '{ST_EX1_IR, ST_UPD_IR, ST_SEL_DR, ST_SEL_IR, ST_TLR};
    tick(1); tick(1); tick(1); tick(1); tick(0); tick(0);
    n_chk++;
    if (state !== ST_SHIFT_IR) begin n_fail++; $display("FAIL to_shift_ir: got %h exp %h", state, ST_SHIFT_IR); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_chk++;
      if (state !== want[i] || upd_ir !== (i == 1)) begin
        n_fail++; $display("FAIL five_ones%0d: got %h/%b exp %h/%b", i, state, upd_ir, want[i], i == 1);
      end
    end
    n_chk++;
    if (tlr !== 1'b1) begin n_fail++; $display("FAIL five_ones_tlr: got %b exp 1", tlr); end
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < $urandom_range(1, 12); i++) tick(1'($urandom));
      for (int i = 0; i < 5; i++) tick(1);
      n_chk++;
      if (state !== ST_TLR) begin n_fail++; $display("FAIL rand_five%0d: got %h exp %h", j, state, ST_TLR); end
    end
  endtask

  task automatic test_random_4wire();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL rand4w%0d: got %h exp %h", i, dut_v, exp_v()); end
    end
  endtask

  task automatic test_2wire_frames();
    logic [2:0] bits = 3'b100;
    do_reset();
    sel = 1'b1;
    tick(1);
    goto_shdr();
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < FR; c++) begin
        n_chk++;
        if (sh_en !== (c == 1) || tms_oe !== (c == FR - 1) || tdo_en !== 1'b0) begin
          n_fail++; $display("FAIL frame%0d_clk%0d: got en=%b oe=%b tdo=%b exp en=%b oe=%b tdo=0",
                             f, c + 1, sh_en, tms_oe, tdo_en, c == 1, c == FR - 1);
        end
        n_chk++;
        if (dut_v !== exp_v()) begin n_fail++; $display("FAIL frame%0d_outs%0d: got %h exp %h", f, c, dut_v, exp_v()); end
        tick((c == 0) ? bits[f] : 1'($urandom));
      end
    n_chk++;
    if (state !== ST_EX1_DR) begin n_fail++; $display("FAIL frame_exit: got %h exp %h", state, ST_EX1_DR); end
  endtask

  task automatic test_mode_toggle();
    sel = 1'b0;
    do_reset();
    tick(1);
    goto_shdr();
    sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0);
      n_chk++;
      if ({tdo_en, tms_oe, sh_en} !== 3'b101) begin
        n_fail++; $display("FAIL sel_ignored%0d: got %b exp 101", i, {tdo_en, tms_oe, sh_en});
      end
    end
    for (int i = 0; i < 5; i++) tick(1);
    tick(1);
    goto_shdr();
    n_chk++;
    if ({tdo_en, sh_en} !== 2'b00 || dut_v !== exp_v()) begin
      n_fail++; $display("FAIL sel_after_tlr: got %h exp %h", dut_v, exp_v());
    end
  endtask

  task automatic test_trst_mid_frame();
    do_reset();
    sel = 1'b1;
    tick(1);
    goto_shdr();
    tick(0); tick(1);
    n_chk++;
    if (m_k != 2 || dut_v !== exp_v()) begin n_fail++; $display("FAIL pre_trst: got %h exp %h", dut_v, exp_v()); end
    #2;
    trst_b = 1'b0;
    #1;
    n_chk++;
    if (dut_v !== {2'b00, 1'b1, 7'b0, ST_TLR}) begin
      n_fail++; $display("FAIL trst_async: got %h exp %h", dut_v, {2'b00, 1'b1, 7'b0, ST_TLR});
    end
    m_st = S_TLR; m_k = 0; m_mode = 0;
    trst_b = 1'b1;
    sel = 1'b0;
    tick(1);
    goto_shdr();
    n_chk++;
    if (dut_v !== exp_v() || tdo_en !== 1'b1) begin
      n_fail++; $display("FAIL after_trst: got %h exp %h", dut_v, exp_v());
    end
  endtask

  task automatic test_tap_en();
    logic [4:0] seq = 5'b01010;
    do_reset();
    tick(1);
    for (int i = 0; i < 5; i++) tick(seq[i]);
    n_chk++;
    if (state !== ST_PAUSE_DR) begin n_fail++; $display("FAIL to_pause: got %h exp %h", state, ST_PAUSE_DR); end
    tap_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(i[0]);
      n_chk++;
      if (state !== ST_TLR || tlr !== 1'b1) begin
        n_fail++; $display("FAIL tap_en_low%0d: got %h exp %h", i, state, ST_TLR);
      end
    end
    tap_en = 1'b1;
    tick(0);
    n_chk++;
    if (state !== ST_RTI) begin n_fail++; $display("FAIL tap_en_back: got %h exp %h", state, ST_RTI); end
  endtask

  task automatic test_random_2wire();
    do_reset();
    sel = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tap_en = ($urandom_range(0, 30) != 0);
      sel = ($urandom_range(0, 5) != 0);
      tick(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      n_chk++;
      if (dut_v !== exp_v()) begin n_fail++; $display("FAIL rand2w%0d: got %h exp %h", i, dut_v, exp_v()); end
    end
    tap_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_4wire_path();
    test_tlr_by_five();
    test_random_4wire();
    test_2wire_frames();
    test_mode_toggle();
    test_trst_mid_frame();
    test_tap_en();
    test_random_2wire();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
